// File: rtl/io_scan_harness.sv
// Scan-style test harness: shifts a stimulus vector in, applies it to a DUT,
// waits a programmable settle time, captures the DUT response and shifts it out.
module io_scan_harness #(
    parameter int WIDTH  = 128,
    parameter int WAIT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WAIT_W-1:0] wait_cycles,
    input  logic              scan_in,
    output logic [WIDTH-1:0]  dut_in,
    input  logic [WIDTH-1:0]  dut_out,
    output logic              scan_out,
    output logic              scan_out_valid,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SHIFT_IN  = 3'd1,
        S_APPLY     = 3'd2,
        S_WAIT      = 3'd3,
        S_CAPTURE   = 3'd4,
        S_SHIFT_OUT = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   bit_cnt_r;
    logic [CNT_W-1:0]   bit_cnt_next_s;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [WAIT_W-1:0]  wait_cnt_next_s;
    logic [WAIT_W-1:0]  wait_lat_r;
    logic [WAIT_W-1:0]  wait_lat_next_s;
    logic [WIDTH-1:0]   shadow_in_r;
    logic [WIDTH-1:0]   shadow_in_next_s;
    logic [WIDTH-1:0]   shadow_out_r;
    logic [WIDTH-1:0]   shadow_out_next_s;
    logic [WIDTH-1:0]   dut_in_next_s;

    // Next-state and datapath update logic for the transaction sequencer.
    always_comb begin
        state_next_s      = state_r;
        bit_cnt_next_s    = bit_cnt_r;
        wait_cnt_next_s   = wait_cnt_r;
        wait_lat_next_s   = wait_lat_r;
        shadow_in_next_s  = shadow_in_r;
        shadow_out_next_s = shadow_out_r;
        dut_in_next_s     = dut_in;

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s    = S_SHIFT_IN;
                    bit_cnt_next_s  = {CNT_W{1'b0}};
                    wait_cnt_next_s = {WAIT_W{1'b0}};
                    wait_lat_next_s = wait_cycles;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_SHIFT_IN: begin
                shadow_in_next_s = {scan_in, shadow_in_r[WIDTH-1:1]};
                if (bit_cnt_r == LAST_BIT) begin
                    state_next_s   = S_APPLY;
                    bit_cnt_next_s = {CNT_W{1'b0}};
                end else begin
                    bit_cnt_next_s = bit_cnt_r + CNT_W'(1);
                end
            end
            S_APPLY: begin
                dut_in_next_s   = shadow_in_r;
                wait_cnt_next_s = {WAIT_W{1'b0}};
                if (wait_lat_r == {WAIT_W{1'b0}}) begin
                    state_next_s = S_CAPTURE;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_WAIT: begin
                // Terminal count is W-1 so W = 2^WAIT_W-1 never needs an extra bit.
                if (wait_cnt_r == (wait_lat_r - WAIT_W'(1))) begin
                    state_next_s = S_CAPTURE;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + WAIT_W'(1);
                end
            end
            S_CAPTURE: begin
                shadow_out_next_s = dut_out;
                bit_cnt_next_s    = {CNT_W{1'b0}};
                state_next_s      = S_SHIFT_OUT;
            end
            S_SHIFT_OUT: begin
                shadow_out_next_s = {1'b0, shadow_out_r[WIDTH-1:1]};
                if (bit_cnt_r == LAST_BIT) begin
                    state_next_s   = S_DONE;
                    bit_cnt_next_s = {CNT_W{1'b0}};
                end else begin
                    bit_cnt_next_s = bit_cnt_r + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; outputs are decoded from the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= S_IDLE;
            bit_cnt_r      <= {CNT_W{1'b0}};
            wait_cnt_r     <= {WAIT_W{1'b0}};
            wait_lat_r     <= {WAIT_W{1'b0}};
            shadow_in_r    <= {WIDTH{1'b0}};
            shadow_out_r   <= {WIDTH{1'b0}};
            dut_in         <= {WIDTH{1'b0}};
            scan_out       <= 1'b0;
            scan_out_valid <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            bit_cnt_r      <= bit_cnt_next_s;
            wait_cnt_r     <= wait_cnt_next_s;
            wait_lat_r     <= wait_lat_next_s;
            shadow_in_r    <= shadow_in_next_s;
            shadow_out_r   <= shadow_out_next_s;
            dut_in         <= dut_in_next_s;
            scan_out       <= (state_next_s == S_SHIFT_OUT) ? shadow_out_next_s[0] : 1'b0;
            scan_out_valid <= (state_next_s == S_SHIFT_OUT);
            busy           <= (state_next_s != S_IDLE);
            done           <= (state_next_s == S_DONE);
        end
    end

endmodule

// File: tb/tb_io_scan_harness.sv
// Scoreboard bench for io_scan_harness driving a small model DUT: an 8-bit adder
// (OUT[39:32] = IN[7:0] + IN[15:8]) and a two-stage register chain from IN[0].
module tb_io_scan_harness;

    localparam int WIDTH  = 128;
    localparam int WAIT_W = 8;

    logic              clk = 1'b0;
    logic              clk_run = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [WAIT_W-1:0] wait_cycles = '0;
    logic              scan_in = 1'b0;
    logic [WIDTH-1:0]  dut_in;
    logic [WIDTH-1:0]  dut_out;
    logic              scan_out;
    logic              scan_out_valid;
    logic              busy;
    logic              done;

    logic r1 = 1'b0;
    logic r2 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [WIDTH-1:0] exp_q[$];

    io_scan_harness #(.WIDTH(WIDTH), .WAIT_W(WAIT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .wait_cycles   (wait_cycles),
        .scan_in       (scan_in),
        .dut_in        (dut_in),
        .dut_out       (dut_out),
        .scan_out      (scan_out),
        .scan_out_valid(scan_out_valid),
        .busy          (busy),
        .done          (done)
    );

    initial begin
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        r1 <= dut_in[0];
        r2 <= r1;
    end

    always_comb begin
        dut_out        = '0;
        dut_out[39:32] = dut_in[7:0] + dut_in[15:8];
        dut_out[1:0]   = {r2, r1};
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] resp(input logic [7:0] sum, input logic [1:0] regs);
        logic [WIDTH-1:0] v;
        v        = '0;
        v[39:32] = sum;
        v[1:0]   = regs;
        return v;
    endfunction

    // Monitor: assemble serial response bits and compare against the scoreboard.
    initial begin
        logic [WIDTH-1:0] bits;
        logic [WIDTH-1:0] e;
        int cnt;
        bits = '0;
        cnt  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt = 0;
            end else begin
                if (done) done_cnt++;
                if (scan_out_valid) begin
                    bits[cnt] = scan_out;
                    cnt++;
                    if (cnt == WIDTH) begin
                        cnt = 0;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_response: got %h with nothing expected", bits);
                        end else begin
                            e = exp_q.pop_front();
                            check("scan_response", bits, e);
                        end
                    end
                end else begin
                    check("scan_out_idle", {{(WIDTH-1){1'b0}}, scan_out}, '0);
                end
            end
        end
    end

    task automatic run_txn(input logic [WIDTH-1:0] vec, input int w,
                           input logic [WIDTH-1:0] exp, input bit lockout, input bit abort);
        int n;
        int d0;
        if (!abort) exp_q.push_back(exp);
        @(negedge clk);
        d0          = done_cnt;
        start       = 1'b1;
        wait_cycles = WAIT_W'(w);
        @(negedge clk);
        start = 1'b0;
        n     = 0;
        check("busy_after_start", {{(WIDTH-1){1'b0}}, busy}, 1);
        for (int i = 0; i < WIDTH; i++) begin
            scan_in = vec[i];
            if (lockout && i == 5)  wait_cycles = '0;
            if (lockout && i == 20) start = 1'b1;
            if (lockout && i == 21) start = 1'b0;
            @(negedge clk);
            n++;
        end
        scan_in = 1'b0;
        while (busy && n < 1000) begin
            start = (lockout && n == 2 * WIDTH) ? 1'b1 : 1'b0;
            if (abort && n == WIDTH + w + 2 + 60) begin
                rst = 1'b1;
                #1;
                check("abort_valid", {{(WIDTH-1){1'b0}}, scan_out_valid}, '0);
                check("abort_dut_in", dut_in, '0);
                check("abort_busy", {{(WIDTH-1){1'b0}}, busy}, '0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                repeat (5) @(negedge clk);
                check("abort_no_done", WIDTH'(done_cnt - d0), '0);
                check("abort_idle", {{(WIDTH-1){1'b0}}, busy}, '0);
                return;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("txn_length", WIDTH'(n), WIDTH'(2 * WIDTH + w + 3));
        check("done_pulses", WIDTH'(done_cnt - d0), WIDTH'(1));
        repeat (3) @(negedge clk);
        check("idle_after_done", {{(WIDTH-1){1'b0}}, busy}, '0);
        check("dut_in_held", dut_in, vec);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_dut_in", dut_in, '0);
        check("rst_outputs", {{(WIDTH-4){1'b0}}, scan_out, scan_out_valid, busy, done}, '0);
        clk_run = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("busy_after_release", {{(WIDTH-1){1'b0}}, busy}, '0);

        run_txn(WIDTH'(16'h0305), 0, resp(8'h08, 2'b00), 1'b0, 1'b0);
        run_txn(WIDTH'(16'h01FF), 0, resp(8'h00, 2'b11), 1'b0, 1'b0);
        run_txn(WIDTH'(16'h0000), 0, resp(8'h00, 2'b11), 1'b0, 1'b0);
        run_txn(WIDTH'(16'h0001), 0, resp(8'h01, 2'b00), 1'b0, 1'b0);
        run_txn(WIDTH'(16'h0000), 0, resp(8'h00, 2'b11), 1'b0, 1'b0);
        run_txn(WIDTH'(16'h0001), 1, resp(8'h01, 2'b01), 1'b0, 1'b0);
        run_txn(WIDTH'(16'h0000), 0, resp(8'h00, 2'b11), 1'b0, 1'b0);
        run_txn(WIDTH'(16'h0001), 2, resp(8'h01, 2'b11), 1'b0, 1'b0);
        run_txn(WIDTH'(16'h0305), 3, resp(8'h08, 2'b11), 1'b1, 1'b0);
        run_txn(WIDTH'(16'h0001), 0, '0, 1'b0, 1'b1);
        run_txn(WIDTH'(16'h0305), 1, resp(8'h08, 2'b01), 1'b0, 1'b0);
        run_txn(WIDTH'(16'h0000), 255, resp(8'h00, 2'b00), 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", WIDTH'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
